// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: synchronise, debounce and round-robin serialise button presses onto a valid/ready port; BTN_AUTOREPEAT_EN adds hold-to-repeat events
module btn_event_arbiter #(
  parameter int N_BTN = 7,
  parameter int TICK_DIV = 25000,
  parameter int STABLE_CNT = 8,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_RATE = 100,
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_db,
  output logic             evt_valid,
  output logic [IW-1:0]    evt_id,
  input  logic             evt_ready,
  output logic             evt_drop
);
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;
  logic [N_BTN-1:0] sync1_q, sync2_q, btn_db_q, btn_db_d, pend_q, pend_d, press, set, clr;
  logic [CW-1:0] cnt_q [N_BTN];
  logic [CW-1:0] cnt_d [N_BTN];
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] ptr_q, ptr_d, evt_id_q, evt_id_d, sel;
  logic evt_drop_q, evt_drop_d, tick, accept, found;
  assign tick = presc_q == PW'(TICK_DIV - 1);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  always_comb begin
    btn_db_d = btn_db_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == btn_db_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == CW'(STABLE_CNT - 1)) begin
          btn_db_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  assign press = btn_db_d & ~btn_db_q;
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE) + 1);
  logic [RW-1:0] rpt_q [N_BTN];
  logic [RW-1:0] rpt_d [N_BTN];
  logic [N_BTN-1:0] rep_q, rep_d, fire;
  // rep_q marks that the initial delay has elapsed, so the counter now measures the repeat period
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      fire[i] = tick && btn_db_q[i] && btn_db_d[i] &&
                (rpt_q[i] + 1'b1 == (rep_q[i] ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY)));
      rpt_d[i] = (!btn_db_d[i] || press[i] || fire[i]) ? '0 : tick ? rpt_q[i] + 1'b1 : rpt_q[i];
      rep_d[i] = btn_db_d[i] && !press[i] && (rep_q[i] || fire[i]);
    end
  end
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      rep_q <= '0;
      for (int i = 0; i < N_BTN; i++) rpt_q[i] <= '0;
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < N_BTN; i++) rpt_q[i] <= rpt_d[i];
    end
  assign set = press | fire;
`else
  assign set = press;
`endif
  always_comb begin
    sel = ptr_q;
    found = 1'b0;
    for (int k = N_BTN - 1; k >= 0; k--)
      if (pend_q[(int'(ptr_q) + k) % N_BTN]) begin
        sel = IW'((int'(ptr_q) + k) % N_BTN);
        found = 1'b1;
      end
  end
  assign accept = (state_q == OFFER) && evt_ready;
  always_comb
    for (int i = 0; i < N_BTN; i++) clr[i] = accept && (evt_id_q == IW'(i));
  // a press landing on its own accept cycle survives as a fresh event rather than a drop
  assign pend_d = (pend_q & ~clr) | set;
  assign evt_drop_d = |(set & pend_q & ~clr);
  always_comb begin
    state_d = accept ? IDLE : (state_q == IDLE && found) ? OFFER : state_q;
    evt_id_d = (state_q == IDLE && found) ? sel : evt_id_q;
    ptr_d = !accept ? ptr_q : (evt_id_q == IW'(N_BTN - 1)) ? '0 : evt_id_q + 1'b1;
  end
  always_ff @(posedge clk_25mhz or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      btn_db_q <= '0;
      pend_q <= '0;
      ptr_q <= '0;
      evt_id_q <= '0;
      evt_drop_q <= 1'b0;
      state_q <= IDLE;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      btn_db_q <= btn_db_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      evt_id_q <= evt_id_d;
      evt_drop_q <= evt_drop_d;
      state_q <= state_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  assign btn_db = btn_db_q;
  assign evt_valid = state_q == OFFER;
  assign evt_id = evt_id_q;
  assign evt_drop = evt_drop_q;
endmodule
